ysyx_22050854_fetch_ctrl: RTL
=============================

YSYX_22050854_FETCH_CTRL -- requirements
Module: ysyx_22050854_fetch_ctrl

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h80000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port redirect_valid, input, 1 bit: a taken jump, branch or csr pc change from the branch unit.
REQ-005 The block SHALL have the port redirect_pc, input, 32 bits: the redirect target.
REQ-006 The block SHALL have the port req_valid, output, 1 bit: instruction-memory request valid.
REQ-007 The block SHALL have the port req_addr, output, 32 bits: the request address.
REQ-008 The block SHALL have the port req_ready, input, 1 bit: memory accepts the request.
REQ-009 The block SHALL have the port rsp_valid, input, 1 bit: memory response valid, one-cycle pulse per accepted request.
REQ-010 The block SHALL have the port rsp_data, input, 32 bits: the instruction word.
REQ-011 The block SHALL have the port if_valid, output, 1 bit: an instruction is presented to ID.
REQ-012 The block SHALL have the port if_pc, output, 32 bits: the pc of the presented instruction.
REQ-013 The block SHALL have the port if_inst, output, 32 bits: the presented instruction.
REQ-014 The block SHALL have the port id_ready, input, 1 bit: ID consumes the instruction; the source deasserts it on a data conflict or suspend.

Function
REQ-015 The block SHALL keep a 32-bit fetch_pc register, a 1-bit discard flag, a 32-bit inst register and a 3-state FSM: REQ, WAIT, HOLD.
REQ-016 The block SHALL drive req_valid = (state==REQ) & ~redirect_valid & ~rst, and SHALL drive req_addr = fetch_pc.
REQ-017 The block SHALL drive if_valid = (state==HOLD) & ~redirect_valid & ~rst, if_pc = fetch_pc and if_inst = inst.
REQ-018 The block SHALL store the redirect target with redirect_pc[1:0] forced to 2'b00 wherever it loads fetch_pc from redirect_pc.
REQ-019 In REQ, on redirect_valid the block SHALL set fetch_pc to the redirect target and stay in REQ; otherwise, when req_ready is 1, it SHALL go to WAIT.
REQ-020 In WAIT with rsp_valid=1 and (discard=1 or redirect_valid=1), the block SHALL drop the response, clear discard and go to REQ, loading fetch_pc from redirect_pc if redirect_valid=1.
REQ-021 In WAIT with rsp_valid=1, discard=0 and redirect_valid=0, the block SHALL capture rsp_data into inst and go to HOLD.
REQ-022 In WAIT with rsp_valid=0 and redirect_valid=1, the block SHALL set discard to 1, load fetch_pc from redirect_pc and stay in WAIT, so the stale response is dropped.
REQ-023 In HOLD, redirect_valid SHALL take priority: the block SHALL discard the held instruction, load fetch_pc from redirect_pc and go to REQ.
REQ-024 In HOLD with id_ready=1 and no redirect, the block SHALL set fetch_pc to fetch_pc+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0) and go to REQ.
REQ-025 In HOLD with id_ready=0 and no redirect, the block SHALL hold state, fetch_pc and inst unchanged.
REQ-026 The block SHALL allow at most one outstanding memory request at any time.
REQ-027 Load-to-use latency SHALL be 1 cycle after the rsp_valid=1 cycle: if_valid=1 in the next cycle.

Reset
REQ-028 While rst=1 the block SHALL force req_valid=0 and if_valid=0.
REQ-029 On a clock edge with rst=1 the block SHALL set state=REQ, fetch_pc=RESET_PC, discard=0 and inst=0.
REQ-030 Reset asserted mid-request SHALL abandon the request, and any rsp_valid arriving after reset deasserts while the FSM is not in WAIT SHALL be ignored.

Verification
REQ-031 The bench SHALL cover reset release with req_ready=1 and a response one cycle later with rsp_data=32'h00000013 -> req_addr=32'h80000000, then if_valid=1, if_pc=32'h80000000, if_inst=32'h00000013.
REQ-032 The bench SHALL cover sequential flow with id_ready=1 throughout -> successive req_addr values 32'h80000000, 32'h80000004 and 32'h80000008.
REQ-033 The bench SHALL cover id_ready=0 held for 5 cycles in HOLD -> if_valid=1 and if_pc/if_inst stable, with no new request issued.
REQ-034 The bench SHALL cover redirect_valid=1 with redirect_pc=32'h80000102 in WAIT, response 3 cycles later -> response dropped, next req_addr=32'h80000100, if_valid stays 0 until the new response.
REQ-035 The bench SHALL cover a redirect in HOLD together with id_ready=1 -> redirect wins, next req_addr=redirect target, held instruction never consumed.
REQ-036 The bench SHALL cover a redirect to 32'hFFFFFFFC followed by consumption -> next req_addr=32'h00000000.

Source files
------------

// File: rtl/ysyx_22050854_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22050854_fetch_ctrl
//
// Instruction fetch controller. It issues one instruction-memory request at a
// time, captures the returned word and presents it to the decode stage until
// decode consumes it or a redirect discards it.
//
// Handshake rules:
//   - A request transfers on a cycle where req_valid & req_ready are both 1.
//     Exactly one rsp_valid pulse follows each accepted request, at least one
//     cycle later.
//   - An instruction transfers to decode on a cycle where if_valid & id_ready
//     are both 1. Decode may hold id_ready low for any number of cycles.
//   - redirect_valid overrides both handshakes in the cycle it is high.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   redirect_valid   taken jump / branch / csr pc change
//   redirect_pc      redirect target (low two bits are ignored)
//   req_valid        instruction-memory request valid
//   req_addr         request address
//   req_ready        memory accepts the request
//   rsp_valid        memory response valid (one pulse per accepted request)
//   rsp_data         instruction word
//   if_valid         instruction presented to decode
//   if_pc, if_inst   pc and word of the presented instruction
//   id_ready         decode consumes the presented instruction
//   dbg_state_o      current FSM state (0 = REQ, 1 = WAIT, 2 = HOLD)
// ----------------------------------------------------------------------------
module ysyx_22050854_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        discard_q, discard_d;
  logic [31:0] redirect_tgt;

  // Instructions are word aligned; the low bits of a redirect are dropped.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // A redirect in the same cycle suppresses both handshakes so that neither a
  // request to the old path nor the old instruction ever transfers.
  assign req_valid   = (state_q == S_REQ)  & ~redirect_valid & ~rst;
  assign req_addr    = fetch_pc_q;
  assign if_valid    = (state_q == S_HOLD) & ~redirect_valid & ~rst;
  assign if_pc       = fetch_pc_q;
  assign if_inst     = inst_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_d     = inst_q;
    discard_d  = discard_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
        end else if (req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (discard_q || redirect_valid) begin
            // Response belongs to an abandoned path: drop it and refetch.
            discard_d = 1'b0;
            state_d   = S_REQ;
            if (redirect_valid) begin
              fetch_pc_d = redirect_tgt;
            end
          end else begin
            inst_d  = rsp_data;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          // The request is still in flight; remember to drop its response.
          discard_d  = 1'b1;
          fetch_pc_d = redirect_tgt;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
          state_d    = S_REQ;
        end else if (id_ready) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      inst_q     <= 32'd0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_q     <= inst_d;
      discard_q  <= discard_d;
    end
  end

endmodule
